// File: rtl/obj_fetch_sequencer_if.sv
// Signal bundle between the OBJ fetch sequencer and its neighbours: OAM evaluation, obj_address_unit, VRAM and the OBJ line buffer.
interface obj_fetch_sequencer_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 8
);
  logic              start;
  logic              abort;
  logic [9:0]        objname;
  logic [2:0]        bgmode;
  logic              palettemode;
  logic              oam_mode;
  logic [6:0]        hsize;
  logic [5:0]        row;
  logic [9:0]        au_objname;
  logic [2:0]        au_bgmode;
  logic              au_palettemode;
  logic              au_oam_mode;
  logic [6:0]        au_hsize;
  logic [5:0]        au_y;
  logic [5:0]        au_x;
  logic [ADDR_W-1:0] au_addr;
  logic              vram_req;
  logic [ADDR_W-1:0] vram_addr;
  logic              vram_gnt;
  logic              vram_rvalid;
  logic [DATA_W-1:0] vram_rdata;
  logic              pix_valid;
  logic [DATA_W-1:0] pix_data;
  logic [5:0]        pix_x;
  logic              pix_ready;
  logic              busy;
  logic              done;

  modport master (
    input  start, abort, objname, bgmode, palettemode, oam_mode, hsize, row,
           au_addr, vram_gnt, vram_rvalid, vram_rdata, pix_ready,
    output au_objname, au_bgmode, au_palettemode, au_oam_mode, au_hsize, au_y, au_x,
           vram_req, vram_addr, pix_valid, pix_data, pix_x, busy, done
  );

  modport slave (
    output start, abort, objname, bgmode, palettemode, oam_mode, hsize, row,
           au_addr, vram_gnt, vram_rvalid, vram_rdata, pix_ready,
    input  au_objname, au_bgmode, au_palettemode, au_oam_mode, au_hsize, au_y, au_x,
           vram_req, vram_addr, pix_valid, pix_data, pix_x, busy, done
  );
endinterface

// File: rtl/obj_fetch_sequencer.sv
// Walks one sprite row: drives the address unit, issues one VRAM byte read per pixel step
// and streams each returned byte to the OBJ line buffer.
module obj_fetch_sequencer #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  obj_fetch_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    OUT   = 3'd3,
    DONE  = 3'd4,
    DRAIN = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [9:0]        objname_q, objname_d;
  logic [2:0]        bgmode_q, bgmode_d;
  logic              pal_q, pal_d;
  logic              oam_q, oam_d;
  logic [6:0]        hsize_q, hsize_d;
  logic [5:0]        row_q, row_d;
  logic [5:0]        x_q, x_d;
  logic [DATA_W-1:0] pix_data_q, pix_data_d;
  logic [5:0]        pix_x_q, pix_x_d;

  logic [6:0]        hsize_clamp_s;
  logic [6:0]        step_s;
  logic [6:0]        x_next_s;
  logic [ADDR_W-1:0] addr_s;

  // x is compared in 7 bits so that a final step landing on 64 does not wrap to 0
  assign hsize_clamp_s = (bus.hsize > 7'd64) ? 7'd64 : bus.hsize;
  assign step_s        = pal_q ? 7'd1 : 7'd2;
  assign x_next_s      = {1'b0, x_q} + step_s;

  // Next-state and attribute/pixel capture logic; abort outranks every other event
  always_comb begin
    state_d    = state_q;
    objname_d  = objname_q;
    bgmode_d   = bgmode_q;
    pal_d      = pal_q;
    oam_d      = oam_q;
    hsize_d    = hsize_q;
    row_d      = row_q;
    x_d        = x_q;
    pix_data_d = pix_data_q;
    pix_x_d    = pix_x_q;
    case (state_q)
      IDLE: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (bus.start) begin
          objname_d = bus.objname;
          bgmode_d  = bus.bgmode;
          pal_d     = bus.palettemode;
          oam_d     = bus.oam_mode;
          hsize_d   = hsize_clamp_s;
          row_d     = bus.row;
          x_d       = 6'd0;
          state_d   = (hsize_clamp_s == 7'd0) ? DONE : REQ;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (bus.vram_gnt) begin
          state_d = bus.abort ? DRAIN : WAIT;
        end else if (bus.abort) begin
          state_d = IDLE;
        end else begin
          state_d = REQ;
        end
      end
      WAIT: begin
        if (bus.vram_rvalid) begin
          if (bus.abort) begin
            state_d = IDLE;
          end else begin
            pix_data_d = bus.vram_rdata;
            pix_x_d    = x_q;
            state_d    = OUT;
          end
        end else if (bus.abort) begin
          state_d = DRAIN;
        end else begin
          state_d = WAIT;
        end
      end
      OUT: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (bus.pix_ready) begin
          x_d     = x_next_s[5:0];
          state_d = (x_next_s >= hsize_q) ? DONE : REQ;
        end else begin
          state_d = OUT;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      DRAIN: begin
        state_d = bus.vram_rvalid ? IDLE : DRAIN;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, latched attributes and the presented pixel
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      objname_q  <= 10'd0;
      bgmode_q   <= 3'd0;
      pal_q      <= 1'b0;
      oam_q      <= 1'b0;
      hsize_q    <= 7'd0;
      row_q      <= 6'd0;
      x_q        <= 6'd0;
      pix_data_q <= {DATA_W{1'b0}};
      pix_x_q    <= 6'd0;
    end else begin
      state_q    <= state_d;
      objname_q  <= objname_d;
      bgmode_q   <= bgmode_d;
      pal_q      <= pal_d;
      oam_q      <= oam_d;
      hsize_q    <= hsize_d;
      row_q      <= row_d;
      x_q        <= x_d;
      pix_data_q <= pix_data_d;
      pix_x_q    <= pix_x_d;
    end
  end

  assign addr_s             = bus.au_addr;
  assign bus.vram_addr      = addr_s;
  assign bus.au_objname     = objname_q;
  assign bus.au_bgmode      = bgmode_q;
  assign bus.au_palettemode = pal_q;
  assign bus.au_oam_mode    = oam_q;
  assign bus.au_hsize       = hsize_q;
  assign bus.au_y           = row_q;
  assign bus.au_x           = x_q;
  assign bus.vram_req       = (state_q == REQ);
  assign bus.pix_valid      = (state_q == OUT);
  assign bus.pix_data       = pix_data_q;
  assign bus.pix_x          = pix_x_q;
  assign bus.busy           = (state_q != IDLE);
  assign bus.done           = (state_q == DONE);

endmodule

// File: tb/tb_obj_fetch_sequencer.sv
// Randomized bench for obj_fetch_sequencer: a row-level model predicts every request address,
// pixel byte/x and the done cycle, and one negedge process compares and drives the handshakes.
module tb_obj_fetch_sequencer;
  localparam int ADDR_W = 15;
  localparam int DATA_W = 8;

  logic clock = 1'b0;
  logic reset_n;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;

  always #5 clock = ~clock;

  obj_fetch_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
  obj_fetch_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Stand-in address unit: 32-byte tile base, 16 bytes/row at 8bpp, 8 bytes/row and x/2 at 4bpp
  function automatic logic [14:0] au_model(logic [9:0] nm, logic pal, logic [5:0] y, logic [5:0] x);
    logic [14:0] base;
    base = {nm, 5'd0};
    if (pal) return base + {5'd0, y, 4'd0} + {9'd0, x};
    else     return base + {6'd0, y, 3'd0} + {10'd0, x[5:1]};
  endfunction

  assign bus.au_addr = au_model(bus.au_objname, bus.au_palettemode, bus.au_y, bus.au_x);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    cyc++;
  endtask

  task automatic set_attrs(input logic [9:0] nm, input logic [2:0] bg, input logic pal,
                           input logic oam, input logic [6:0] hs, input logic [5:0] rw);
    bus.objname = nm; bus.bgmode = bg; bus.palettemode = pal;
    bus.oam_mode = oam; bus.hsize = hs; bus.row = rw;
  endtask

  // One full row; returns model request count and cycle offsets (from the start cycle) of first pixel and done
  task automatic run_row(input logic [9:0] nm, input logic [2:0] bg, input logic pal, input logic oam,
                         input logic [6:0] hs, input logic [5:0] rw,
                         input int gmin, input int gmax, input int lmin, input int lmax,
                         input int rmin, input int rmax, input bit restart, input bit start_on_done,
                         output int n_out, output int first_pix, output int done_at);
    logic [14:0] ea[$];
    int          ex[$];
    logic [7:0]  sent[$];
    int hc, step, n, ri, pi, gw, rdy_w, lat, t0;
    bit pend, seen_done;
    hc   = (hs > 7'd64) ? 64 : int'(hs);
    step = pal ? 1 : 2;
    for (int x = 0; x < hc; x += step) begin
      ea.push_back(au_model(nm, pal, rw, x[5:0]));
      ex.push_back(x);
    end
    n = ea.size(); n_out = n;
    ri = 0; pi = 0; pend = 1'b0; seen_done = 1'b0; lat = 0;
    first_pix = -1; done_at = -1;
    gw    = $urandom_range(gmax, gmin);
    rdy_w = $urandom_range(rmax, rmin);
    tick();
    set_attrs(nm, bg, pal, oam, hs, rw);
    bus.start = 1'b1;
    t0 = cyc;
    for (int c = 0; c < 3000 && !seen_done; c++) begin
      tick();
      bus.start = 1'b0;
      if (restart && c == 5) begin
        set_attrs(~nm, ~bg, ~pal, ~oam, 7'd3, ~rw);
        bus.start = 1'b1;
      end
      chk("busy_in_row", bus.busy, 1'b1);
      chk("au_objname", bus.au_objname, nm);
      chk("au_bgmode", bus.au_bgmode, bg);
      chk("au_palettemode", bus.au_palettemode, pal);
      chk("au_oam_mode", bus.au_oam_mode, oam);
      chk("au_hsize", bus.au_hsize, hc);
      chk("au_y", bus.au_y, rw);
      bus.vram_rvalid = 1'b0;
      if (pend) begin
        if (lat == 0) begin
          bus.vram_rvalid = 1'b1;
          bus.vram_rdata  = sent[sent.size()-1];
          pend = 1'b0;
        end else begin
          lat--;
        end
      end
      bus.vram_gnt = 1'b0;
      if (bus.vram_req) begin
        if (ri >= n) begin
          chk("req_count", ri, n - 1);
        end else begin
          chk("vram_addr", bus.vram_addr, ea[ri]);
          chk("au_x", bus.au_x, ex[ri]);
          if (gw == 0) begin
            bus.vram_gnt = 1'b1;
            sent.push_back(8'($urandom));
            pend = 1'b1;
            lat  = $urandom_range(lmax, lmin) - 1;
            ri++;
            gw = $urandom_range(gmax, gmin);
          end else begin
            gw--;
          end
        end
      end
      bus.pix_ready = 1'($urandom_range(1, 0));
      if (bus.pix_valid) begin
        if (first_pix < 0) first_pix = cyc - t0;
        if (pi >= sent.size()) begin
          chk("pix_count", pi, sent.size() - 1);
        end else begin
          chk("pix_data", bus.pix_data, sent[pi]);
          chk("pix_x", bus.pix_x, ex[pi]);
        end
        if (rdy_w == 0) begin
          bus.pix_ready = 1'b1;
          pi++;
          rdy_w = $urandom_range(rmax, rmin);
        end else begin
          bus.pix_ready = 1'b0;
          rdy_w--;
        end
      end
      if (bus.done) begin
        seen_done = 1'b1;
        done_at = cyc - t0;
        chk("done_reqs", ri, n);
        chk("done_pixels", pi, n);
        if (start_on_done) begin
          set_attrs(10'h3FF, 3'd7, 1'b1, 1'b1, 7'd9, 6'd9);
          bus.start = 1'b1;
        end
      end
    end
    chk("done_seen", seen_done, 1'b1);
    tick();
    bus.start = 1'b0; bus.vram_gnt = 1'b0; bus.vram_rvalid = 1'b0; bus.pix_ready = 1'b0;
    chk("busy_after_done", bus.busy, 1'b0);
    chk("done_one_cycle", bus.done, 1'b0);
    tick();
    chk("idle_stays", bus.busy, 1'b0);
  endtask

  task automatic abort_in_wait();
    tick();
    set_attrs(10'h010, 3'd0, 1'b1, 1'b1, 7'd16, 6'd2);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("ab_req", bus.vram_req, 1'b1);
    chk("ab_addr", bus.vram_addr, 15'h220);
    bus.vram_gnt = 1'b1;
    tick();
    bus.vram_gnt = 1'b0;
    chk("ab_wait_busy", bus.busy, 1'b1);
    bus.abort = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      bus.abort = 1'b0;
      chk("ab_drain_busy", bus.busy, 1'b1);
      chk("ab_drain_req", bus.vram_req, 1'b0);
      chk("ab_drain_pix", bus.pix_valid, 1'b0);
    end
    bus.vram_rvalid = 1'b1;
    bus.vram_rdata  = 8'hA5;
    for (int i = 0; i < 4; i++) begin
      tick();
      bus.vram_rvalid = 1'b0;
      chk("ab_idle_busy", bus.busy, 1'b0);
      chk("ab_no_pix", bus.pix_valid, 1'b0);
      chk("ab_no_done", bus.done, 1'b0);
      chk("ab_no_a5", bus.pix_data == 8'hA5, 1'b0);
    end
  endtask

  task automatic reset_mid_row();
    tick();
    set_attrs(10'h155, 3'd2, 1'b1, 1'b0, 7'd16, 6'd5);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.vram_gnt = 1'b1;
    tick();
    bus.vram_gnt = 1'b0;
    bus.vram_rvalid = 1'b1;
    bus.vram_rdata  = 8'h3C;
    tick();
    bus.vram_rvalid = 1'b0;
    chk("rst_pre_valid", bus.pix_valid, 1'b1);
    chk("rst_pre_data", bus.pix_data, 8'h3C);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_pix_valid", bus.pix_valid, 1'b0);
    chk("rst_pix_data", bus.pix_data, 8'h00);
    chk("rst_vram_req", bus.vram_req, 1'b0);
    chk("rst_au_objname", bus.au_objname, 10'h000);
    chk("rst_au_hsize", bus.au_hsize, 7'd0);
    chk("rst_vram_addr", bus.vram_addr, 15'h0000);
    tick();
    reset_n = 1'b1;
    tick();
    chk("rst_idle_after", bus.busy, 1'b0);
    chk("rst_no_done", bus.done, 1'b0);
  endtask

  initial begin
    int n, fp, da;
    reset_n = 1'b0;
    bus.start = 1'b0; bus.abort = 1'b0;
    set_attrs(10'd0, 3'd0, 1'b0, 1'b0, 7'd0, 6'd0);
    bus.vram_gnt = 1'b0; bus.vram_rvalid = 1'b0; bus.vram_rdata = 8'd0; bus.pix_ready = 1'b0;
    repeat (3) tick();
    chk("reset_busy", bus.busy, 1'b0);
    chk("reset_req", bus.vram_req, 1'b0);
    chk("reset_pix_valid", bus.pix_valid, 1'b0);
    chk("reset_done", bus.done, 1'b0);
    chk("reset_au_x", bus.au_x, 6'd0);
    chk("reset_pix_data", bus.pix_data, 8'd0);
    reset_n = 1'b1;
    tick();

    chk("pin_addr_8bpp_first", au_model(10'h010, 1'b1, 6'd2, 6'd0), 15'h220);
    chk("pin_addr_8bpp_last", au_model(10'h010, 1'b1, 6'd2, 6'd15), 15'h22F);
    chk("pin_addr_4bpp_x6", au_model(10'h011, 1'b0, 6'd1, 6'd6), 15'h22B);

    run_row(10'h010, 3'd0, 1'b1, 1'b1, 7'd16, 6'd2, 0, 0, 1, 1, 0, 0, 1'b0, 1'b0, n, fp, da);
    chk("t1_reqs", n, 16);
    chk("t1_first_pix", fp, 3);
    chk("t1_done_at", da, 49);

    run_row(10'h011, 3'd0, 1'b0, 1'b1, 7'd8, 6'd1, 0, 0, 1, 1, 0, 0, 1'b0, 1'b0, n, fp, da);
    chk("t2_reqs", n, 4);
    chk("t2_done_at", da, 13);

    run_row(10'h023, 3'd1, 1'b1, 1'b0, 7'd8, 6'd7, 3, 3, 4, 4, 5, 5, 1'b0, 1'b0, n, fp, da);
    chk("bp_done_at", da, 113);

    run_row(10'h0AB, 3'd3, 1'b1, 1'b1, 7'd0, 6'd0, 0, 2, 1, 3, 0, 2, 1'b0, 1'b0, n, fp, da);
    chk("hs0_reqs", n, 0);
    chk("hs0_done_at", da, 1);

    run_row(10'h001, 3'd0, 1'b1, 1'b1, 7'd100, 6'd3, 0, 1, 1, 2, 0, 1, 1'b0, 1'b0, n, fp, da);
    chk("hs100_reqs", n, 64);

    run_row(10'h2C4, 3'd4, 1'b0, 1'b0, 7'd10, 6'd9, 0, 2, 1, 3, 0, 2, 1'b1, 1'b1, n, fp, da);

    abort_in_wait();

    tick();
    set_attrs(10'h050, 3'd0, 1'b1, 1'b1, 7'd8, 6'd0);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("abort_beats_start", bus.busy, 1'b0);

    for (int r = 0; r < 16; r++) begin
      run_row(10'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), 7'($urandom_range(127, 0)),
              6'($urandom), 0, $urandom_range(3, 0), 1, $urandom_range(4, 1), 0, $urandom_range(3, 0),
              1'b0, 1'($urandom), n, fp, da);
    end

    reset_mid_row();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
